// File: rtl/npu_loader_pkg.sv
// Shared FSM type and sizing helpers for the layer parameter loader.
// DATA_WIDTH normally comes from width.svh; the fallback below keeps standalone builds complete.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package npu_loader_pkg;

   typedef enum logic [1:0] {
      LOAD_W = 2'd0,
      LOAD_B = 2'd1,
      COMMIT = 2'd2
   } loader_state_t;

   function automatic int total_words(input int in_n, input int out_n);
      return out_n * in_n + out_n;
   endfunction

   function automatic int cnt_width(input int range_n);
      return (range_n > 1) ? $clog2(range_n) : 1;
   endfunction

endpackage

// File: rtl/layer_param_bank.sv
// Parameter register arrays with a single write port and a commit strobe.
// LOADER_DOUBLE_BUFFER_EN adds a shadow bank so a commit swaps in a whole set at once.
module layer_param_bank
   import npu_loader_pkg::*;
#(
   parameter int IN_N       = 16,
   parameter int OUT_N      = 8,
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int ROW_W      = cnt_width(OUT_N),
   parameter int COL_W      = cnt_width(IN_N)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_wr_en,
   input  logic                         i_wr_bias,
   input  logic [ROW_W-1:0]             i_wr_row,
   input  logic [COL_W-1:0]             i_wr_col,
   input  logic signed [DATA_WIDTH-1:0] i_wr_data,
   input  logic                         i_commit,
   output logic signed [DATA_WIDTH-1:0] o_weights [OUT_N][IN_N],
   output logic signed [DATA_WIDTH-1:0] o_biases  [OUT_N],
   output logic                         o_params_valid
);

   logic signed [DATA_WIDTH-1:0] r_weights [OUT_N][IN_N];
   logic signed [DATA_WIDTH-1:0] r_biases  [OUT_N];
   logic                         r_valid;

`ifdef LOADER_DOUBLE_BUFFER_EN
   logic signed [DATA_WIDTH-1:0] r_shadowW [OUT_N][IN_N];
   logic signed [DATA_WIDTH-1:0] r_shadowB [OUT_N];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < OUT_N; r++) begin
            r_shadowB[r] <= '0;
            for (int c = 0; c < IN_N; c++) r_shadowW[r][c] <= '0;
         end
      end else if (i_wr_en) begin
         if (i_wr_bias) r_shadowB[i_wr_row] <= i_wr_data;
         else           r_shadowW[i_wr_row][i_wr_col] <= i_wr_data;
      end
   end

   // The active bank only ever changes as a whole, so the layer never sees a mixed set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         for (int r = 0; r < OUT_N; r++) begin
            r_biases[r] <= '0;
            for (int c = 0; c < IN_N; c++) r_weights[r][c] <= '0;
         end
      end else if (i_commit) begin
         r_valid <= 1'b1;
         for (int r = 0; r < OUT_N; r++) begin
            r_biases[r] <= r_shadowB[r];
            for (int c = 0; c < IN_N; c++) r_weights[r][c] <= r_shadowW[r][c];
         end
      end
   end
`else
   // Single bank: writes land in the live arrays, so any write marks the set incomplete.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         for (int r = 0; r < OUT_N; r++) begin
            r_biases[r] <= '0;
            for (int c = 0; c < IN_N; c++) r_weights[r][c] <= '0;
         end
      end else begin
         if (i_wr_en) begin
            r_valid <= 1'b0;
            if (i_wr_bias) r_biases[i_wr_row] <= i_wr_data;
            else           r_weights[i_wr_row][i_wr_col] <= i_wr_data;
         end
         if (i_commit) r_valid <= 1'b1;
      end
   end
`endif

   assign o_weights      = r_weights;
   assign o_biases       = r_biases;
   assign o_params_valid = r_valid;

endmodule

// File: rtl/layer_param_loader.sv
// Framed valid/ready loader for a fully connected layer's weight and bias arrays.
// Build with LOADER_DOUBLE_BUFFER_EN for atomic shadow-to-active commits.
module layer_param_loader
   import npu_loader_pkg::*;
#(
   parameter int IN_N       = 16,
   parameter int OUT_N      = 8,
   parameter int DATA_WIDTH = `DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic signed [DATA_WIDTH-1:0] s_data,
   input  logic                         s_last,
   output logic signed [DATA_WIDTH-1:0] weights [OUT_N][IN_N],
   output logic signed [DATA_WIDTH-1:0] biases  [OUT_N],
   output logic                         params_valid,
   output logic                         load_done,
   output logic                         err_len
);

   localparam int ROW_W = cnt_width(OUT_N);
   localparam int COL_W = cnt_width(IN_N);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_N - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_N - 1);

   loader_state_t    r_state;
   logic [ROW_W-1:0] r_row;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_bidx;
   logic             r_errPulse;
   logic             r_donePulse;

   logic             w_accept;
   logic             w_final;
   logic             w_err;
   logic             w_commit;
   logic             w_wrBias;
   logic [ROW_W-1:0] w_wrRow;

   assign s_ready  = !rst && (r_state != COMMIT);
   assign w_accept = s_valid && s_ready;
   assign w_final  = (r_state == LOAD_B) && (r_bidx == LAST_ROW);
   // s_last must coincide exactly with the last bias word; any disagreement aborts the load.
   assign w_err    = w_accept && (s_last != w_final);
   assign w_commit = (r_state == COMMIT);
   assign w_wrBias = (r_state == LOAD_B);
   assign w_wrRow  = w_wrBias ? r_bidx : r_row;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= LOAD_W;
         r_row       <= '0;
         r_col       <= '0;
         r_bidx      <= '0;
         r_errPulse  <= 1'b0;
         r_donePulse <= 1'b0;
      end else begin
         r_errPulse  <= w_err;
         r_donePulse <= w_commit;
         if (w_err) begin
            r_state <= LOAD_W;
            r_row   <= '0;
            r_col   <= '0;
            r_bidx  <= '0;
         end else begin
            case (r_state)
               LOAD_W: begin
                  if (w_accept) begin
                     if (r_col == LAST_COL) begin
                        r_col <= '0;
                        if (r_row == LAST_ROW) begin
                           r_row   <= '0;
                           r_state <= LOAD_B;
                        end else begin
                           r_row <= r_row + 1'b1;
                        end
                     end else begin
                        r_col <= r_col + 1'b1;
                     end
                  end
               end
               LOAD_B: begin
                  if (w_accept) begin
                     if (r_bidx == LAST_ROW) begin
                        r_bidx  <= '0;
                        r_state <= COMMIT;
                     end else begin
                        r_bidx <= r_bidx + 1'b1;
                     end
                  end
               end
               COMMIT: begin
                  r_state <= LOAD_W;
                  r_row   <= '0;
                  r_col   <= '0;
                  r_bidx  <= '0;
               end
               default: r_state <= LOAD_W;
            endcase
         end
      end
   end

   layer_param_bank #(
      .IN_N      (IN_N),
      .OUT_N     (OUT_N),
      .DATA_WIDTH(DATA_WIDTH),
      .ROW_W     (ROW_W),
      .COL_W     (COL_W)
   ) u_bank (
      .clk           (clk),
      .rst           (rst),
      .i_wr_en       (w_accept),
      .i_wr_bias     (w_wrBias),
      .i_wr_row      (w_wrRow),
      .i_wr_col      (r_col),
      .i_wr_data     (s_data),
      .i_commit      (w_commit),
      .o_weights     (weights),
      .o_biases      (biases),
      .o_params_valid(params_valid)
   );

   assign load_done = r_donePulse;
   assign err_len   = r_errPulse;

endmodule

// File: doc/layer_param_loader.md
# layer_param_loader

Streams signed weight and bias words over a valid/ready interface and fills the parallel parameter arrays that drive a fully connected layer's `weights[OUT_N][IN_N]` and `biases[OUT_N]` inputs. It is the writer side of the layer's parameter interface. It frames a load with `s_last`, checks the load length, and commits a complete parameter set atomically. The layer therefore never computes with a half-written set.

## Interface
- `IN_N`, 16, input vector dimensionality (columns per weight row)
- `OUT_N`, 8, neuron count (weight rows, bias entries)
- `DATA_WIDTH`, `` `DATA_WIDTH ``, signed word width
- `clk` input 1: system clock
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `s_valid` input 1: stream word valid
- `s_ready` output 1: loader can accept a word
- `s_data` input DATA_WIDTH: signed parameter word
- `s_last` input 1: marks the final word of a load
- `weights` output DATA_WIDTH × [OUT_N][IN_N]: active weights, fed to the layer
- `biases` output DATA_WIDTH × [OUT_N]: active biases
- `params_valid` output 1: active arrays hold a complete committed load
- `load_done` output 1: one-cycle pulse when a commit takes effect
- `err_len` output 1: one-cycle pulse when a load is aborted for a framing error

## Operation
- **Beat acceptance:** a beat is accepted when `s_valid && s_ready`.
- **Word order:** a load is exactly `TOTAL = OUT_N*IN_N + OUT_N` words.
  - Weights first, row-major: `w[0][0]..w[0][IN_N-1]`, `w[1][0]`, …
  - Then biases `b[0]..b[OUT_N-1]`.
- **FSM states:**
  - `LOAD_W`: row/column counters advance on each accepted beat. The column counter wraps at `IN_N-1` and increments the row. After row `OUT_N-1`, column `IN_N-1`, go to `LOAD_B`.
  - `LOAD_B`: the bias counter advances per beat. The accepted beat at `OUT_N-1` goes to `COMMIT`.
  - `COMMIT`: copy the shadow arrays to the active arrays, clear the counters, return to `LOAD_W`.
- **Writes:** accepted words are written to the shadow arrays.
- **`s_ready`:** 1 in `LOAD_W` and `LOAD_B`, 0 in `COMMIT` and while `rst` is high.
- **Framing errors:**
  - `s_last` on any beat other than word `TOTAL-1` is an error.
  - Word `TOTAL-1` accepted without `s_last` is also an error.
  - On either error: pulse `err_len`, reset the counters to `LOAD_W`, and leave the active arrays and `params_valid` unchanged. The offending beat is consumed. The shadow contents are don't-care.
- **Arithmetic:** no arithmetic on data; words are stored verbatim. Counter widths are `$clog2` of their range, minimum 1 bit.
- **Back-to-back loads:** the first word of the next load may be presented during `COMMIT`. It is accepted in the following cycle.

## Timing
- **Reset values:** all `weights`/`biases` = 0; `params_valid`, `load_done`, `err_len` = 0; FSM in `LOAD_W` with counters 0.
- **After reset:** `s_ready` = 1 in the first cycle after `rst` deasserts.
- **Commit latency:** final beat accepted in cycle t → `COMMIT` in t+1. New `weights`/`biases` and `params_valid`=1 are visible from t+2. `load_done` = 1 in t+2 only.
- **Error latency:** error beat accepted in cycle t → `err_len` = 1 in t+1 only; `s_ready` stays 1.
- **Throughput:** one word per cycle, plus one bubble per load.
- **Reset mid-load:** discard progress and return all outputs to their reset values, including previously committed parameters.
- **Upstream stall:** `s_valid` low holds all state.

## Configuration
- **`LOADER_DOUBLE_BUFFER_EN` defined:** shadow plus active banks, with atomic commit as described above.
- **Undefined:** single bank.
  - Accepted words write the active arrays directly.
  - `params_valid` drops to 0 the cycle after the first accepted beat of a load, and rises at commit with the same t+2 timing.
  - On a framing error, partially written contents remain and `params_valid` stays 0.

## Structure
- **`npu_loader_pkg`:** the FSM state enum typedef `loader_state_t` (`LOAD_W`, `LOAD_B`, `COMMIT`) and a `total_words(in_n, out_n)` function. `DATA_WIDTH` continues to come from `width.svh`.
- **`layer_param_bank`:** one sub-module, the register array with a write port (row, column, bias-select, data), a commit input and the macro-controlled shadow. The top level holds the FSM, counters and framing check.

## Test plan
All scenarios use `IN_N=2`, `OUT_N=2`, so `TOTAL` = 6.
- **Basic load:** after reset, stream 1,2,3,4,5,6 with `s_last` on the sixth word → from t+2, `weights` = {{1,2},{3,4}}, `biases` = {5,6}, `params_valid` = 1, `load_done` pulses once.
- **Early `s_last`:** `s_last` on word 4 of a second load 9..12 → `err_len` pulses, arrays still {{1,2},{3,4}}/{5,6}, `params_valid` = 1.
- **Missing `s_last`:** sixth word without `s_last` → `err_len` pulses, no commit. The next clean load of 7..12 commits correctly.
- **Bursty upstream:** random `s_valid` gaps during a load of -1,-2,-3,-4,-5,-6 → signed values stored exactly, with one `load_done`.
- **Back-to-back loads:** two loads streamed back to back → `s_ready` = 0 only in each `COMMIT` cycle, and both commits observed in order.
- **Reset mid-load:** `rst` after word 3 → all outputs 0, `s_ready` = 1 next cycle, and a fresh load then succeeds.
